lc2k_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage LC2K core (IF, ID, EX, MEM, WB).
- Shadows every instruction that leaves ID through internal EX/MEM/WB tracking slots.
- From those slots it drives stall, bubble, flush and forwarding selects around the decode stage and register file.
- Also owns the halt-drain sequence and two saturating hazard statistics counters.

---
 rtl/lc2k_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_lc2k_hazard_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_hazard_ctrl.sv
// rtl/lc2k_hazard_ctrl.sv - LC2K 5-stage pipeline hazard, forwarding and halt-drain controller
// Optional macro LC2K_FWD_EN: EX/MEM/WB forwarding with load-use-only stalls.
module lc2k_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_opcode,
    input  logic [REG_W-1:0] id_regA,
    input  logic [REG_W-1:0] id_regB,
    input  logic [REG_W-1:0] id_dest,
    input  logic             mem_br_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;
    state_t r_state, w_state_nxt;

    logic             r_ex_v, r_ex_wr, r_ex_halt;
    logic             r_mem_v, r_mem_wr, r_mem_halt;
    logic             r_wb_v, r_wb_wr, r_wb_halt;
    logic [REG_W-1:0] r_ex_wreg, r_mem_wreg, r_wb_wreg;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic             w_rd_a, w_rd_b, w_wr, w_is_halt;
    logic [REG_W-1:0] w_wreg;
    logic             w_ma_ex, w_ma_mem, w_ma_wb, w_mb_ex, w_mb_mem, w_mb_wb;
    logic             w_raw, w_hazard, w_flush, w_stall, w_id_adv;

    assign w_rd_a    = (id_opcode <= 3'd5);
    assign w_rd_b    = (id_opcode == 3'd0) || (id_opcode == 3'd1) ||
                       (id_opcode == 3'd3) || (id_opcode == 3'd4);
    assign w_wr      = (id_opcode == 3'd0) || (id_opcode == 3'd1) ||
                       (id_opcode == 3'd2) || (id_opcode == 3'd5);
    assign w_wreg    = ((id_opcode == 3'd2) || (id_opcode == 3'd5)) ? id_regB : id_dest;
    assign w_is_halt = (id_opcode == 3'd6);

    assign w_ma_ex  = id_valid && w_rd_a && r_ex_v  && r_ex_wr  && (r_ex_wreg  == id_regA);
    assign w_ma_mem = id_valid && w_rd_a && r_mem_v && r_mem_wr && (r_mem_wreg == id_regA);
    assign w_ma_wb  = id_valid && w_rd_a && r_wb_v  && r_wb_wr  && (r_wb_wreg  == id_regA);
    assign w_mb_ex  = id_valid && w_rd_b && r_ex_v  && r_ex_wr  && (r_ex_wreg  == id_regB);
    assign w_mb_mem = id_valid && w_rd_b && r_mem_v && r_mem_wr && (r_mem_wreg == id_regB);
    assign w_mb_wb  = id_valid && w_rd_b && r_wb_v  && r_wb_wr  && (r_wb_wreg  == id_regB);

`ifdef LC2K_FWD_EN
    logic       r_ex_lw;
    logic [1:0] r_fwd_a, r_fwd_b;

    function automatic logic [1:0] f_sel(input logic ex, input logic mem, input logic wb);
        return ex ? 2'd1 : (mem ? 2'd2 : (wb ? 2'd3 : 2'd0));
    endfunction

    assign w_raw = (w_ma_ex || w_mb_ex) && r_ex_lw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_lw <= 1'b0;
            r_fwd_a <= 2'd0;
            r_fwd_b <= 2'd0;
        end else begin
            r_ex_lw <= w_id_adv && (id_opcode == 3'd2);
            r_fwd_a <= w_id_adv ? f_sel(w_ma_ex, w_ma_mem, w_ma_wb) : 2'd0;
            r_fwd_b <= w_id_adv ? f_sel(w_mb_ex, w_mb_mem, w_mb_wb) : 2'd0;
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    // No bypass: the regfile only holds the value once the producer has left WB.
    assign w_raw     = w_ma_ex || w_mb_ex || w_ma_mem || w_mb_mem || w_ma_wb || w_mb_wb;
    assign fwd_a_sel = 2'd0;
    assign fwd_b_sel = 2'd0;
`endif

    assign w_hazard = w_raw && (r_state == ST_RUN);
    assign w_flush  = mem_br_taken && (r_state != ST_HALTED);
    assign w_stall  = w_hazard && !w_flush;
    assign w_id_adv = (r_state == ST_RUN) && id_valid && !w_hazard && !w_flush;

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_stall) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                if (w_id_adv && w_is_halt) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                stall_if = !w_flush;
                // A redirect kills a halt that has not yet reached WB.
                if (w_flush && !(r_wb_v && r_wb_halt)) w_state_nxt = ST_RUN;
                else if (r_wb_v && r_wb_halt)          w_state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_ex_v      <= 1'b0;
            r_mem_v     <= 1'b0;
            r_wb_v      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_v     <= w_id_adv;
            r_ex_wr    <= w_wr;
            r_ex_wreg  <= w_wreg;
            r_ex_halt  <= w_is_halt;
            r_mem_v    <= r_ex_v && !w_flush;
            r_mem_wr   <= r_ex_wr;
            r_mem_wreg <= r_ex_wreg;
            r_mem_halt <= r_ex_halt;
            r_wb_v     <= r_mem_v;
            r_wb_wr    <= r_mem_wr;
            r_wb_wreg  <= r_mem_wreg;
            r_wb_halt  <= r_mem_halt;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign flush     = w_flush;
    assign halted    = (r_state == ST_HALTED);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_lc2k_hazard_ctrl.sv
// tb/tb_lc2k_hazard_ctrl.sv - directed self-checking bench for lc2k_hazard_ctrl
module tb_lc2k_hazard_ctrl;
    localparam int CNT_W = 16;
    localparam int REG_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [2:0]       id_opcode;
    logic [REG_W-1:0] id_regA, id_regB, id_dest;
    logic             mem_br_taken;
    logic             stall_if, stall_id, bubble_ex, flush, halted;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc2k_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_regA(id_regA), .id_regB(id_regB), .id_dest(id_dest),
        .mem_br_taken(mem_br_taken), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .halted(halted), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] d);
        id_valid  = v;
        id_opcode = op;
        id_regA   = a;
        id_regB   = b;
        id_dest   = d;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        mem_br_taken = 1'b0;
        drive(1'b0, 3'd7, 3'd0, 3'd0, 3'd0);
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_tests++;
        if ({stall_if, stall_id, bubble_ex, flush} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctl: {stall_if,stall_id,bubble_ex,flush}=%b expected 0000",
                     {stall_if, stall_id, bubble_ex, flush});
        end
        n_tests++;
        if ({fwd_a_sel, fwd_b_sel, halted} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_regs: fwd_a=%0d fwd_b=%0d halted=%b expected 0 0 0",
                     fwd_a_sel, fwd_b_sel, halted);
        end
        n_tests++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: stall_cnt=%0d flush_cnt=%0d expected 0 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_raw_add_add();
        do_reset();
        drive(1'b1, 3'd0, 3'd2, 3'd3, 3'd1);
        settle();
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL addadd_first: stall_if=%b expected 0", stall_if);
        end
        adv();
        drive(1'b1, 3'd0, 3'd1, 3'd1, 3'd4);
`ifdef LC2K_FWD_EN
        settle();
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL addadd_nostall: stall_if=%b expected 0", stall_if);
        end
        adv();
        id_valid = 1'b0;
        settle();
        n_tests++;
        if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL addadd_fwd: fwd_a=%0d fwd_b=%0d expected 1 1", fwd_a_sel, fwd_b_sel);
        end
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL addadd_cnt: stall_cnt=%0d expected 0", stall_cnt);
        end
`else
        for (int c = 0; c < 3; c++) begin
            settle();
            n_tests++;
            if ({stall_if, stall_id, bubble_ex} !== 3'b111) begin
                n_fail++;
                $display("FAIL addadd_stall_c%0d: {stall_if,stall_id,bubble_ex}=%b expected 111",
                         c, {stall_if, stall_id, bubble_ex});
            end
            adv();
        end
        settle();
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL addadd_release: stall_if=%b expected 0", stall_if);
        end
        n_tests++;
        if (stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL addadd_cnt: stall_cnt=%0d expected 3", stall_cnt);
        end
        adv();
        id_valid = 1'b0;
        settle();
        n_tests++;
        if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL addadd_fwd_off: fwd_a=%0d fwd_b=%0d expected 0 0", fwd_a_sel, fwd_b_sel);
        end
`endif
    endtask

    task automatic test_load_use();
        int exp_stalls;
`ifdef LC2K_FWD_EN
        exp_stalls = 1;
`else
        exp_stalls = 3;
`endif
        do_reset();
        drive(1'b1, 3'd2, 3'd5, 3'd2, 3'd0);
        settle();
        adv();
        drive(1'b1, 3'd0, 3'd2, 3'd3, 3'd4);
        for (int c = 0; c < exp_stalls; c++) begin
            settle();
            n_tests++;
            if ({stall_if, stall_id, bubble_ex} !== 3'b111) begin
                n_fail++;
                $display("FAIL loaduse_stall_c%0d: {stall_if,stall_id,bubble_ex}=%b expected 111",
                         c, {stall_if, stall_id, bubble_ex});
            end
            adv();
        end
        settle();
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_release: stall_if=%b expected 0", stall_if);
        end
        adv();
        id_valid = 1'b0;
        settle();
        n_tests++;
        if (stall_cnt !== 16'(exp_stalls)) begin
            n_fail++;
            $display("FAIL loaduse_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_stalls);
        end
`ifdef LC2K_FWD_EN
        n_tests++;
        if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL loaduse_fwd: fwd_a=%0d fwd_b=%0d expected 2 0", fwd_a_sel, fwd_b_sel);
        end
`endif
    endtask

    task automatic test_flush_priority();
        do_reset();
        drive(1'b1, 3'd4, 3'd0, 3'd0, 3'd0);
        adv();
        drive(1'b1, 3'd2, 3'd5, 3'd2, 3'd0);
        adv();
        drive(1'b1, 3'd0, 3'd2, 3'd3, 3'd4);
        mem_br_taken = 1'b1;
        settle();
        n_tests++;
        if ({flush, stall_if, stall_id, bubble_ex} !== 4'b1000) begin
            n_fail++;
            $display("FAIL flush_prio: {flush,stall_if,stall_id,bubble_ex}=%b expected 1000",
                     {flush, stall_if, stall_id, bubble_ex});
        end
        adv();
        mem_br_taken = 1'b0;
        settle();
        n_tests++;
        if ({flush, stall_if} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_slots_cleared: {flush,stall_if}=%b expected 00", {flush, stall_if});
        end
        n_tests++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL flush_cnt: flush_cnt=%0d stall_cnt=%0d expected 1 0", flush_cnt, stall_cnt);
        end
        adv();
        id_valid = 1'b0;
        settle();
        n_tests++;
        if (fwd_a_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_no_fwd: fwd_a=%0d expected 0", fwd_a_sel);
        end
    endtask

    task automatic test_halt_drain();
        do_reset();
        drive(1'b1, 3'd6, 3'd0, 3'd0, 3'd0);
        settle();
        n_tests++;
        if (stall_if !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_issue: stall_if=%b halted=%b expected 0 0", stall_if, halted);
        end
        adv();
        drive(1'b1, 3'd0, 3'd1, 3'd1, 3'd1);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_tests++;
            if (stall_if !== 1'b1 || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_drain_c%0d: stall_if=%b halted=%b expected 1 0", c, stall_if, halted);
            end
            adv();
        end
        for (int c = 0; c < 2; c++) begin
            settle();
            n_tests++;
            if ({halted, stall_if, stall_id, bubble_ex} !== 4'b1111) begin
                n_fail++;
                $display("FAIL halt_halted_c%0d: {halted,stall_if,stall_id,bubble_ex}=%b expected 1111",
                         c, {halted, stall_if, stall_id, bubble_ex});
            end
            adv();
        end
    endtask

    task automatic test_halt_flush();
        do_reset();
        drive(1'b1, 3'd6, 3'd0, 3'd0, 3'd0);
        adv();
        id_valid     = 1'b0;
        mem_br_taken = 1'b1;
        settle();
        n_tests++;
        if (flush !== 1'b1) begin
            n_fail++;
            $display("FAIL haltflush_flush: flush=%b expected 1", flush);
        end
        adv();
        mem_br_taken = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_tests++;
            if (halted !== 1'b0 || stall_if !== 1'b0) begin
                n_fail++;
                $display("FAIL haltflush_run_c%0d: halted=%b stall_if=%b expected 0 0", c, halted, stall_if);
            end
            adv();
        end
        settle();
        n_tests++;
        if (flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL haltflush_cnt: flush_cnt=%0d expected 1", flush_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 3'd2, 3'd5, 3'd2, 3'd0);
        adv();
        drive(1'b1, 3'd0, 3'd2, 3'd3, 3'd4);
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        settle();
        n_tests++;
        if (stall_if !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: stall_if=%b stall_cnt=%0d expected 0 0", stall_if, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        int target;
        int seen;
        target = (1 << CNT_W) + 5;
        seen   = 0;
        do_reset();
        drive(1'b1, 3'd2, 3'd1, 3'd1, 3'd0);
        for (int c = 0; c < 200000 && seen < target; c++) begin
            settle();
            if (stall_if === 1'b1) seen++;
            adv();
        end
        n_tests++;
        if (seen < target) begin
            n_fail++;
            $display("FAIL sat_budget: stall cycles seen=%0d expected %0d", seen, target);
        end
        id_valid = 1'b0;
        for (int c = 0; c < 4; c++) adv();
        mem_br_taken = 1'b1;
        adv();
        mem_br_taken = 1'b0;
        drive(1'b1, 3'd6, 3'd0, 3'd0, 3'd0);
        adv();
        id_valid = 1'b0;
        for (int c = 0; c < 3; c++) adv();
        settle();
        n_tests++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_value: stall_cnt=%0h expected ffff", stall_cnt);
        end
        n_tests++;
        if (halted !== 1'b1 || flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL sat_pre_reset: halted=%b flush_cnt=%0d expected 1 1", halted, flush_cnt);
        end
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        settle();
        n_tests++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || halted !== 1'b0 ||
            fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_reset: stall_cnt=%0d flush_cnt=%0d halted=%b fwd_a=%0d fwd_b=%0d stall_if=%b expected all 0",
                     stall_cnt, flush_cnt, halted, fwd_a_sel, fwd_b_sel, stall_if);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_br_taken = 1'b0;
        drive(1'b0, 3'd7, 3'd0, 3'd0, 3'd0);
        test_reset();
        test_raw_add_add();
        test_load_use();
        test_flush_priority();
        test_halt_drain();
        test_halt_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
